// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use bubble insertion, multi-cycle MDU hold and branch flush.
// stall_out freezes the PC and the IF/ID register, so ID re-presents the same instruction
// on the following cycle.
// Optional feature: define HAZARD_PERF_EN to build the saturating stall-cycle counter;
// without it, perf_stall_cnt is tied to zero.
module id_ex_hazard_stage #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MDU_LAT = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [4:0]        id_Rs,
    input  logic [4:0]        id_Rt,
    input  logic [4:0]        id_Rd,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [9:0]        id_ctrl,
    input  logic              id_mdu,
    input  logic              flush,
    output logic              ex_valid,
    output logic [4:0]        ex_Rs,
    output logic [4:0]        ex_Rt,
    output logic [4:0]        ex_Rd,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [9:0]        ex_ctrl,
    output logic              stall_out,
    output logic              mdu_busy,
    output logic [CNT_W-1:0]  perf_stall_cnt
);

    // Bit position of memread inside {regwrite,memread,memwrite,memtoreg,alusrc,regdst,aluop}
    localparam int unsigned CtrlMemRead = 8;
    // Counter start value; MDU_LAT is limited to 2..15 so it fits in 4 bits
    localparam logic [3:0]  MduInit     = 4'(MDU_LAT - 1);

    typedef enum logic [0:0] {
        StIdle,
        StMduBusy
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              kill_pend_q, kill_pend_d;
    logic              mdu_busy_q, mdu_busy_d;

    logic              ex_valid_q, ex_valid_d;
    logic [4:0]        ex_rs_q, ex_rs_d;
    logic [4:0]        ex_rt_q, ex_rt_d;
    logic [4:0]        ex_rd_q, ex_rd_d;
    logic [DATA_W-1:0] ex_rs_data_q, ex_rs_data_d;
    logic [DATA_W-1:0] ex_rt_data_q, ex_rt_data_d;
    logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
    logic [9:0]        ex_ctrl_q, ex_ctrl_d;

    logic              lu;

    // Load-use: the load in EX writes a register the instruction in ID reads
    always_comb begin
        lu = ex_valid_q & ex_ctrl_q[CtrlMemRead] & (ex_rt_q != 5'd0) & id_valid &
             ((ex_rt_q == id_Rs) | (ex_rt_q == id_Rt));
    end

    // Stall while the MDU owns EX, or for the single bubble cycle of a load-use
    always_comb begin
        stall_out = (state_q == StMduBusy) | ((state_q == StIdle) & lu & ~flush);
    end

    // Next-state: choose between hold, bubble and load of the ID fields
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        kill_pend_d  = kill_pend_q;
        mdu_busy_d   = mdu_busy_q;
        ex_valid_d   = ex_valid_q;
        ex_rs_d      = ex_rs_q;
        ex_rt_d      = ex_rt_q;
        ex_rd_d      = ex_rd_q;
        ex_rs_data_d = ex_rs_data_q;
        ex_rt_data_d = ex_rt_data_q;
        ex_imm_d     = ex_imm_q;
        ex_ctrl_d    = ex_ctrl_q;

        unique case (state_q)
            StIdle: begin
                // Every IDLE edge loads something, so a pending kill is consumed here
                kill_pend_d = 1'b0;
                mdu_busy_d  = 1'b0;
                if (flush || kill_pend_q || lu || !id_valid) begin
                    ex_valid_d   = 1'b0;
                    ex_rs_d      = '0;
                    ex_rt_d      = '0;
                    ex_rd_d      = '0;
                    ex_rs_data_d = '0;
                    ex_rt_data_d = '0;
                    ex_imm_d     = '0;
                    ex_ctrl_d    = '0;
                end else begin
                    ex_valid_d   = 1'b1;
                    ex_rs_d      = id_Rs;
                    ex_rt_d      = id_Rt;
                    ex_rd_d      = id_Rd;
                    ex_rs_data_d = id_rs_data;
                    ex_rt_data_d = id_rt_data;
                    ex_imm_d     = id_imm;
                    ex_ctrl_d    = id_ctrl;
                    if (id_mdu) begin
                        state_d    = StMduBusy;
                        cnt_d      = MduInit;
                        mdu_busy_d = 1'b1;
                    end
                end
            end
            StMduBusy: begin
                // The stalled ID instruction cannot be killed yet; remember the flush
                if (flush) begin
                    kill_pend_d = 1'b1;
                end
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = StIdle;
                    mdu_busy_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and EX register update; reset aborts any MDU op immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            kill_pend_q  <= 1'b0;
            mdu_busy_q   <= 1'b0;
            ex_valid_q   <= 1'b0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_rd_q      <= '0;
            ex_rs_data_q <= '0;
            ex_rt_data_q <= '0;
            ex_imm_q     <= '0;
            ex_ctrl_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            kill_pend_q  <= kill_pend_d;
            mdu_busy_q   <= mdu_busy_d;
            ex_valid_q   <= ex_valid_d;
            ex_rs_q      <= ex_rs_d;
            ex_rt_q      <= ex_rt_d;
            ex_rd_q      <= ex_rd_d;
            ex_rs_data_q <= ex_rs_data_d;
            ex_rt_data_q <= ex_rt_data_d;
            ex_imm_q     <= ex_imm_d;
            ex_ctrl_q    <= ex_ctrl_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_Rs      = ex_rs_q;
    assign ex_Rt      = ex_rt_q;
    assign ex_Rd      = ex_rd_q;
    assign ex_rs_data = ex_rs_data_q;
    assign ex_rt_data = ex_rt_data_q;
    assign ex_imm     = ex_imm_q;
    assign ex_ctrl    = ex_ctrl_q;
    assign mdu_busy   = mdu_busy_q;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] perf_q, perf_d;

    // Saturating count of stalled cycles
    always_comb begin
        perf_d = perf_q;
        if (stall_out && (perf_q != {CNT_W{1'b1}})) begin
            perf_d = perf_q + 1'b1;
        end
    end

    // Performance counter register, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stall_cnt = perf_q;
`else
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Scoreboard bench for id_ex_hazard_stage: each directed step pushes the hand-computed
// identity of the instruction expected in EX, plus expected stall/mdu_busy; a monitor
// pops and compares once per clock.
module tb_id_ex_hazard_stage;

    localparam int unsigned DataW = 32;
    localparam int unsigned CntW  = 16;

    logic             clk;
    logic             rst;
    logic             id_valid;
    logic [4:0]       id_Rs, id_Rt, id_Rd;
    logic [DataW-1:0] id_rs_data, id_rt_data, id_imm;
    logic [9:0]       id_ctrl;
    logic             id_mdu;
    logic             flush;
    logic             ex_valid;
    logic [4:0]       ex_Rs, ex_Rt, ex_Rd;
    logic [DataW-1:0] ex_rs_data, ex_rt_data, ex_imm;
    logic [9:0]       ex_ctrl;
    logic             stall_out;
    logic             mdu_busy;
    logic [CntW-1:0]  perf_stall_cnt;

    id_ex_hazard_stage #(
        .DATA_W  (DataW),
        .MDU_LAT (4),
        .CNT_W   (CntW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_Rs          (id_Rs),
        .id_Rt          (id_Rt),
        .id_Rd          (id_Rd),
        .id_rs_data     (id_rs_data),
        .id_rt_data     (id_rt_data),
        .id_imm         (id_imm),
        .id_ctrl        (id_ctrl),
        .id_mdu         (id_mdu),
        .flush          (flush),
        .ex_valid       (ex_valid),
        .ex_Rs          (ex_Rs),
        .ex_Rt          (ex_Rt),
        .ex_Rd          (ex_Rd),
        .ex_rs_data     (ex_rs_data),
        .ex_rt_data     (ex_rt_data),
        .ex_imm         (ex_imm),
        .ex_ctrl        (ex_ctrl),
        .stall_out      (stall_out),
        .mdu_busy       (mdu_busy),
        .perf_stall_cnt (perf_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctrl = {regwrite,memread,memwrite,memtoreg,alusrc,regdst,aluop[3:0]}
    localparam logic [9:0] CtrlAdd  = 10'h212;
    localparam logic [9:0] CtrlLw   = 10'h362;
    localparam logic [9:0] CtrlMult = 10'h00B;

    // Instruction table indexed by id; id 0 means "bubble expected"
    logic       t_v   [0:15];
    logic [4:0] t_rs  [0:15];
    logic [4:0] t_rt  [0:15];
    logic [4:0] t_rd  [0:15];
    logic [9:0] t_ct  [0:15];
    logic       t_mdu [0:15];

    typedef struct {
        int step_no;
        int exp_id;
        bit exp_stall;
        bit exp_busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   step_no = 0;

    function automatic logic [DataW-1:0] rs_data_of(input int id);
        return {16'hA5A5, 16'(id)};
    endfunction
    function automatic logic [DataW-1:0] rt_data_of(input int id);
        return {16'h5A5A, 16'(id)};
    endfunction
    function automatic logic [DataW-1:0] imm_of(input int id);
        return {16'h00C0, 16'(id)};
    endfunction

    task automatic chk(input string name, input int sn, input logic [127:0] act,
                       input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s step %0d: got %0h expected %0h", name, sn, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic def(input int id, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [9:0] ct, input logic mdu);
        t_v[id]   = v;
        t_rs[id]  = rs;
        t_rt[id]  = rt;
        t_rd[id]  = rd;
        t_ct[id]  = ct;
        t_mdu[id] = mdu;
    endtask

    task automatic drive(input int id, input bit fl);
        id_valid   = t_v[id];
        id_Rs      = t_rs[id];
        id_Rt      = t_rt[id];
        id_Rd      = t_rd[id];
        id_ctrl    = t_ct[id];
        id_mdu     = t_mdu[id];
        id_rs_data = rs_data_of(id);
        id_rt_data = rt_data_of(id);
        id_imm     = imm_of(id);
        flush      = fl;
    endtask

    // One clock: present ID instruction `id` and queue what EX must hold after the edge
    task automatic step(input int id, input bit fl, input int exp_id, input bit exp_stall,
                        input bit exp_busy);
        exp_t e;
        @(negedge clk);
        drive(id, fl);
        step_no++;
        e.step_no   = step_no;
        e.exp_id    = exp_id;
        e.exp_stall = exp_stall;
        e.exp_busy  = exp_busy;
        exp_q.push_back(e);
    endtask

    // Monitor: sample stall_out before the edge, registered outputs just after it
    initial begin : monitor
        logic s_stall;
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            s_stall = stall_out;
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.exp_id == 0) begin
                    chk("ex_valid", e.step_no, 128'(ex_valid), 128'(0));
                    chk("ex_regs", e.step_no, 128'({ex_Rs, ex_Rt, ex_Rd}), 128'(0));
                    chk("ex_data", e.step_no, 128'({ex_rs_data, ex_rt_data, ex_imm}), 128'(0));
                    chk("ex_ctrl", e.step_no, 128'(ex_ctrl), 128'(0));
                end else begin
                    chk("ex_valid", e.step_no, 128'(ex_valid), 128'(1));
                    chk("ex_regs", e.step_no, 128'({ex_Rs, ex_Rt, ex_Rd}),
                        128'({t_rs[e.exp_id], t_rt[e.exp_id], t_rd[e.exp_id]}));
                    chk("ex_data", e.step_no, 128'({ex_rs_data, ex_rt_data, ex_imm}),
                        128'({rs_data_of(e.exp_id), rt_data_of(e.exp_id), imm_of(e.exp_id)}));
                    chk("ex_ctrl", e.step_no, 128'(ex_ctrl), 128'(t_ct[e.exp_id]));
                end
                chk("stall_out", e.step_no, 128'(s_stall), 128'(e.exp_stall));
                chk("mdu_busy", e.step_no, 128'(mdu_busy), 128'(e.exp_busy));
            end
        end
    end

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 10) begin
            @(negedge clk);
            k++;
        end
        n_total++;
        if (exp_q.size() != 0) begin
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end else begin
            n_pass++;
        end
    endtask

    initial begin : stim
        def(0,  1'b0, 5'd0,  5'd0,  5'd0,  10'h000,  1'b0);
        def(1,  1'b1, 5'd1,  5'd2,  5'd3,  CtrlAdd,  1'b0);
        def(2,  1'b1, 5'd1,  5'd2,  5'd3,  CtrlAdd,  1'b0);
        def(3,  1'b1, 5'd1,  5'd5,  5'd0,  CtrlLw,   1'b0);
        def(4,  1'b1, 5'd5,  5'd6,  5'd7,  CtrlAdd,  1'b0);
        def(5,  1'b1, 5'd1,  5'd0,  5'd0,  CtrlLw,   1'b0);
        def(6,  1'b1, 5'd0,  5'd2,  5'd8,  CtrlAdd,  1'b0);
        def(7,  1'b1, 5'd8,  5'd9,  5'd0,  CtrlMult, 1'b1);
        def(8,  1'b1, 5'd10, 5'd11, 5'd12, CtrlAdd,  1'b0);
        def(9,  1'b1, 5'd3,  5'd4,  5'd0,  CtrlMult, 1'b1);
        def(10, 1'b1, 5'd2,  5'd3,  5'd4,  CtrlAdd,  1'b0);
        def(11, 1'b1, 5'd4,  5'd5,  5'd6,  10'h216,  1'b0);
        def(12, 1'b0, 5'd5,  5'd5,  5'd1,  CtrlLw,   1'b1);
        def(13, 1'b1, 5'd6,  5'd7,  5'd0,  CtrlMult, 1'b1);
        def(14, 1'b0, 5'd0,  5'd0,  5'd0,  10'h000,  1'b0);
        def(15, 1'b0, 5'd0,  5'd0,  5'd0,  10'h000,  1'b0);

        rst = 1'b1;
        drive(0, 1'b0);
        repeat (2) @(negedge clk);
        chk("reset_ex_valid", 0, 128'(ex_valid), 128'(0));
        chk("reset_ex_fields", 0, 128'({ex_Rs, ex_Rt, ex_Rd, ex_ctrl, ex_imm}), 128'(0));
        chk("reset_busy_stall", 0, 128'({mdu_busy, stall_out}), 128'(0));
        chk("reset_perf", 0, 128'(perf_stall_cnt), 128'(0));
        rst = 1'b0;

        // id, flush, expected EX id, expected stall (pre-edge), expected mdu_busy (post-edge)
        step(1, 0, 1, 0, 0);    // plain flow
        step(2, 0, 2, 0, 0);
        step(1, 0, 1, 0, 0);
        step(3, 0, 3, 0, 0);    // lw $5 into EX
        step(4, 0, 0, 1, 0);    // add uses $5 -> stall, bubble
        step(4, 0, 4, 0, 0);    // add enters EX
        step(5, 0, 5, 0, 0);    // lw $0
        step(6, 0, 6, 0, 0);    // use of $0: no stall
        step(3, 0, 3, 0, 0);
        step(4, 1, 0, 0, 0);    // flush beats load-use
        step(7, 0, 7, 0, 1);    // mult enters EX
        step(8, 0, 7, 1, 1);
        step(8, 0, 7, 1, 1);
        step(8, 0, 7, 1, 0);
        step(8, 0, 8, 0, 0);    // next instruction after MDU_LAT cycles in EX
        step(7, 0, 7, 0, 1);    // back-to-back MDU
        step(9, 0, 7, 1, 1);
        step(9, 0, 7, 1, 1);
        step(9, 0, 7, 1, 0);
        step(9, 0, 9, 0, 1);    // second mult enters MDU_BUSY with no gap
        step(10, 0, 9, 1, 1);
        step(10, 1, 9, 1, 1);   // flush on 2nd busy cycle
        step(10, 0, 9, 1, 0);
        step(10, 0, 0, 0, 0);   // killed instruction becomes bubble
        step(11, 0, 11, 0, 0);  // next loads normally
        step(12, 0, 0, 0, 0);   // invalid ID: bubble, no MDU entry
        step(11, 0, 11, 0, 0);
        step(13, 0, 13, 0, 1);  // mult for reset test
        drain();

        // Asynchronous reset while MDU_BUSY
        drive(11, 1'b0);
        #2;
        chk("pre_rst_busy", 0, 128'({mdu_busy, stall_out}), 128'(2'b11));
        rst = 1'b1;
        #1;
        chk("async_rst_ex", 0, 128'({ex_valid, ex_Rs, ex_Rt, ex_Rd, ex_ctrl}), 128'(0));
        chk("async_rst_data", 0, 128'({ex_rs_data, ex_rt_data, ex_imm}), 128'(0));
        chk("async_rst_busy_stall", 0, 128'({mdu_busy, stall_out}), 128'(0));
        chk("async_rst_perf", 0, 128'(perf_stall_cnt), 128'(0));
        @(negedge clk);
        rst = 1'b0;

        // Three load-use stalls after reset
        for (int i = 0; i < 3; i++) begin
            step(3, 0, 3, 0, 0);
            step(4, 0, 0, 1, 0);
            step(4, 0, 4, 0, 0);
        end
        drain();
        @(posedge clk);
        #1;
`ifdef HAZARD_PERF_EN
        chk("perf_after_3_stalls", 0, 128'(perf_stall_cnt), 128'(3));
`else
        chk("perf_tied_zero", 0, 128'(perf_stall_cnt), 128'(0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global time limit so the bench can never hang
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
